// File: rtl/generador_pasos_pkg.sv
// Shared definitions for the generador_pasos step generator:
// FSM state encoding and the width of the inter-pulse gap counter.
package pasos_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] PULSE = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    // Width of the gap countdown; enough for GAP values 1..15.
    localparam int GAP_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_SETUP = SETUP,
        S_PULSE = PULSE,
        S_GAP   = GAP
    } estado_t;

endpackage

// File: rtl/generador_pasos_if.sv
// Bus between the step generator and its environment.
// Optional macro GENERADOR_PASOS_ABORT_EN adds the abort request line.
//
// Handshake: a target transfers on a rising clk edge where tgt_valid and
// tgt_ready are both 1. tgt_ready is 1 only while the generator is idle;
// tgt_valid seen while tgt_ready is 0 is ignored, nothing is queued.
interface generador_pasos_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] tgt;
    logic             tgt_valid;
    logic             tgt_ready;
    logic             full;
    logic             empty;
    logic             nxt;
    logic             dir;
    logic [WIDTH-1:0] pos;
    logic             busy;
    logic             done;
    logic             err;
`ifdef GENERADOR_PASOS_ABORT_EN
    logic             abort;
`endif

    modport master (
`ifdef GENERADOR_PASOS_ABORT_EN
        output abort,
`endif
        output tgt, tgt_valid, full, empty,
        input  tgt_ready, nxt, dir, pos, busy, done, err
    );

    modport slave (
`ifdef GENERADOR_PASOS_ABORT_EN
        input  abort,
`endif
        input  tgt, tgt_valid, full, empty,
        output tgt_ready, nxt, dir, pos, busy, done, err
    );

endinterface

// File: rtl/generador_pasos_temporizador_gap.sv
// Countdown that times the low cycles between step pulses.
// Loaded with (gap - 1); expire is high once the count reaches zero.
module temporizador_gap
    import pasos_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [GAP_W-1:0] val_i,
    input  logic             count_i,
    output logic             expire_o
);

    logic [GAP_W-1:0] cnt_q, cnt_d;

    // Next count: load has priority, otherwise count down to zero and stop.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/generador_pasos.sv
// Step generator: accepts a target counter value and issues one-cycle nxt
// pulses (with a fixed direction) until its internal mirror reaches it,
// aborting with err if the counter reports a limit.
// Optional macro GENERADOR_PASOS_ABORT_EN adds an abort request.
module generador_pasos #(
    parameter int WIDTH = 2,
    parameter int GAP   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    generador_pasos_if.slave    bus,
    output pasos_pkg::estado_t  estado_o
);
    import pasos_pkg::GAP_W;
    import pasos_pkg::estado_t;
    import pasos_pkg::S_IDLE;
    import pasos_pkg::S_SETUP;
    import pasos_pkg::S_PULSE;
    import pasos_pkg::S_GAP;

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

    estado_t          state_q, state_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             accept;
    logic             limit;
    logic             abort_w;
    logic             nxt_w;
    logic             gap_load;
    logic             gap_expire;

    assign accept = bus.tgt_valid && bus.tgt_ready;
    // The counter limit that matters depends on the direction of travel.
    assign limit  = dir_q ? bus.full : bus.empty;

`ifdef GENERADOR_PASOS_ABORT_EN
    assign abort_w = bus.abort;
`else
    assign abort_w = 1'b0;
`endif

    // Next-state and output decode for the move sequencer.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        tgt_d    = tgt_q;
        dir_d    = dir_q;
        err_d    = err_q;
        done_d   = 1'b0;
        nxt_w    = 1'b0;
        gap_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.tgt == pos_q) begin
                        done_d = 1'b1;
                    end else begin
                        tgt_d   = bus.tgt;
                        dir_d   = (bus.tgt > pos_q);
                        err_d   = 1'b0;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (abort_w) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                if (limit) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    nxt_w = 1'b1;
                    pos_d = dir_q ? (pos_q + WIDTH'(1)) : (pos_q - WIDTH'(1));
                    // An abort here lets the current pulse finish first.
                    if (abort_w) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        gap_load = 1'b1;
                        state_d  = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (abort_w) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (gap_expire) begin
                    if (pos_q == tgt_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_PULSE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any move in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            tgt_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    temporizador_gap u_gap (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (gap_load),
        .val_i    (GAP_LOAD),
        .count_i  (state_q == S_GAP),
        .expire_o (gap_expire)
    );

    // Ready is gated by rst_n so it reads 0 for the whole reset interval.
    assign bus.tgt_ready = rst_n && (state_q == S_IDLE);
    assign bus.nxt       = nxt_w;
    assign bus.dir       = dir_q;
    assign bus.pos       = pos_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign estado_o      = state_q;

endmodule

// File: tb/tb_generador_pasos.sv
// Self-checking bench for generador_pasos with WIDTH=2, GAP=1.
module tb_generador_pasos;

    localparam int WIDTH = 2;
    localparam int GAP   = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    generador_pasos_if #(.WIDTH(WIDTH)) bus ();
    pasos_pkg::estado_t estado;

    generador_pasos #(.WIDTH(WIDTH), .GAP(GAP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .estado_o (estado)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Expected mirror value after each observed nxt pulse.
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_pos;
    logic             chk_pend   = 1'b0;
    logic             full_force = 1'b0;

    // External up/down counter driven by nxt/dir, re-zeroed by reset.
    logic [WIDTH-1:0] ctr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ctr <= '0;
        else if (bus.nxt) ctr <= bus.dir ? ctr + 1'b1 : ctr - 1'b1;
    end
    assign bus.full  = (ctr == '1) || full_force;
    assign bus.empty = (ctr == '0);

    // Scoreboard: one negedge after each pulse, pos must match the queue head.
    always @(negedge clk) begin
        if (chk_pend) begin
            chk_pend = 1'b0;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL pulse_unexpected: pos=%0d, no pulse expected", bus.pos);
            end else begin
                exp_pos = exp_q.pop_front();
                if (bus.pos !== exp_pos)
                    $display("FAIL pulse_pos: got %0d want %0d", bus.pos, exp_pos);
                else
                    n_pass++;
            end
        end
        if (bus.nxt === 1'b1) chk_pend = 1'b1;
    end

    task automatic test_reset();
        bus.tgt       = '0;
        bus.tgt_valid = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.nxt, bus.dir, bus.pos, bus.busy, bus.done, bus.err, bus.tgt_ready} !== 8'd0)
            $display("FAIL reset_outputs: got nxt=%b dir=%b pos=%0d busy=%b done=%b err=%b rdy=%b want all 0",
                     bus.nxt, bus.dir, bus.pos, bus.busy, bus.done, bus.err, bus.tgt_ready);
        else n_pass++;
        n_checks++;
        if (estado !== pasos_pkg::S_IDLE)
            $display("FAIL reset_state: got %0d want 0", estado);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.tgt_ready !== 1'b1)
            $display("FAIL reset_ready_after: got %b want 1", bus.tgt_ready);
        else n_pass++;
    endtask

    // Drive one move and follow it to done, checking pulse timing and result.
    task automatic run_move(input string name, input logic [WIDTH-1:0] t,
                            input logic [WIDTH-1:0] start, input int n_pulses,
                            input bit up, input int done_cyc, input int force_cyc,
                            input bit hold_valid, input logic [WIDTH-1:0] exp_end,
                            input bit exp_err);
        int  cyc;
        int  seen;
        bit  done_seen;
        for (int i = 1; i <= n_pulses; i++)
            exp_q.push_back(up ? start + WIDTH'(i) : start - WIDTH'(i));
        @(negedge clk);
        n_checks++;
        if (bus.tgt_ready !== 1'b1)
            $display("FAIL %s_ready: got %b want 1", name, bus.tgt_ready);
        else n_pass++;
        bus.tgt       = t;
        bus.tgt_valid = 1'b1;
        cyc       = 0;
        seen      = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                if (hold_valid) bus.tgt = t - 2'd1;
                else bus.tgt_valid = 1'b0;
                n_checks++;
                if ({bus.dir, bus.busy, bus.nxt, bus.tgt_ready} !== {up, 1'b1, 1'b0, 1'b0})
                    $display("FAIL %s_setup: got dir=%b busy=%b nxt=%b rdy=%b want dir=%b busy=1 nxt=0 rdy=0",
                             name, bus.dir, bus.busy, bus.nxt, bus.tgt_ready, up);
                else n_pass++;
            end
            if (cyc == force_cyc) full_force = 1'b1;
            if (bus.nxt === 1'b1) begin
                seen++;
                n_checks++;
                if (cyc != 2 * seen || bus.dir !== up)
                    $display("FAIL %s_pulse_timing: pulse %0d at cycle %0d dir=%b want cycle %0d dir=%b",
                             name, seen, cyc, bus.dir, 2 * seen, up);
                else n_pass++;
            end
            if (bus.done === 1'b1) begin
                done_seen     = 1'b1;
                bus.tgt_valid = 1'b0;
            end
        end
        n_checks++;
        if (!done_seen || cyc != done_cyc)
            $display("FAIL %s_done: seen=%b at cycle %0d want cycle %0d", name, done_seen, cyc, done_cyc);
        else n_pass++;
        n_checks++;
        if (seen != n_pulses)
            $display("FAIL %s_pulse_count: got %0d want %0d", name, seen, n_pulses);
        else n_pass++;
        n_checks++;
        if ({bus.pos, bus.err, bus.busy} !== {exp_end, exp_err, 1'b0})
            $display("FAIL %s_end: got pos=%0d err=%b busy=%b want pos=%0d err=%b busy=0",
                     name, bus.pos, bus.err, bus.busy, exp_end, exp_err);
        else n_pass++;
        @(negedge clk);
        full_force = 1'b0;
        n_checks++;
        if ({bus.done, bus.nxt, bus.busy} !== 3'b000)
            $display("FAIL %s_after: got done=%b nxt=%b busy=%b want 0 0 0", name, bus.done, bus.nxt, bus.busy);
        else n_pass++;
    endtask

    task automatic test_same_target();
        int pulses;
        @(negedge clk);
        bus.tgt       = 2'd1;
        bus.tgt_valid = 1'b1;
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        n_checks++;
        if ({bus.done, bus.busy, bus.nxt} !== 3'b100)
            $display("FAIL same_done: got done=%b busy=%b nxt=%b want 1 0 0", bus.done, bus.busy, bus.nxt);
        else n_pass++;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.nxt === 1'b1 || bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0 || bus.pos !== 2'd1)
            $display("FAIL same_quiet: got %0d active cycles pos=%0d want 0 and pos=1", pulses, bus.pos);
        else n_pass++;
    endtask

    task automatic test_reset_mid_move();
        int  cyc;
        int  pulses;
        // The pulse in flight is wiped by reset, so pos reads 0 after it.
        exp_q.push_back(2'd0);
        @(negedge clk);
        bus.tgt       = 2'd3;
        bus.tgt_valid = 1'b1;
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        cyc = 0;
        while (bus.nxt !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (bus.nxt !== 1'b1)
            $display("FAIL rstmid_pulse_wait: got no pulse within %0d cycles want one", cyc);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.nxt, bus.pos, bus.busy, bus.tgt_ready} !== 5'd0)
            $display("FAIL rstmid_async: got nxt=%b pos=%0d busy=%b rdy=%b want all 0",
                     bus.nxt, bus.pos, bus.busy, bus.tgt_ready);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.nxt === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0 || bus.pos !== 2'd0 || bus.busy !== 1'b0)
            $display("FAIL rstmid_quiet: got pulses=%0d pos=%0d busy=%b want 0 0 0", pulses, bus.pos, bus.busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_move("b2b_down", 2'd0, 2'd1, 1, 1'b0, 4, 0, 1'b0, 2'd0, 1'b0);
        run_move("b2b_up",   2'd2, 2'd0, 2, 1'b1, 6, 0, 1'b0, 2'd2, 1'b0);
    endtask

    initial begin
`ifdef GENERADOR_PASOS_ABORT_EN
        bus.abort = 1'b0;
`endif
        test_reset();
        run_move("up", 2'd3, 2'd0, 3, 1'b1, 8, 0, 1'b0, 2'd3, 1'b0);
        run_move("down", 2'd1, 2'd3, 2, 1'b0, 6, 0, 1'b0, 2'd1, 1'b0);
        test_same_target();
        test_reset_mid_move();
        run_move("limit", 2'd3, 2'd0, 1, 1'b1, 5, 3, 1'b1, 2'd1, 1'b1);
        test_back_to_back();
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
